// File: rtl/dnn_pkg.sv
// Shared definitions for the DNN CPU datapath blocks.
package dnn_pkg;

  localparam int unsigned DNN_DATA_W  = 32;
  localparam int unsigned DNN_MAX_LEN = 16;

  typedef enum logic [1:0] {
    IDLE,
    ACCUM,
    DONE
  } stateT;

endpackage

// File: rtl/lt_cmp32.sv
// 32-bit less-than comparator with selectable signed/unsigned ordering.
module lt_cmp32
  import dnn_pkg::*;
(
  input  logic [DNN_DATA_W-1:0] a,
  input  logic [DNN_DATA_W-1:0] b,
  input  logic                  uMod,
  output logic                  lt
);

  logic [DNN_DATA_W-1:0] aKey;
  logic [DNN_DATA_W-1:0] bKey;

  // Flipping the sign bit maps two's complement order onto unsigned order.
  always_comb begin
    aKey = a;
    bKey = b;
    if (!uMod) begin
      aKey[DNN_DATA_W-1] = ~a[DNN_DATA_W-1];
      bKey[DNN_DATA_W-1] = ~b[DNN_DATA_W-1];
    end
    lt = (aKey < bKey);
  end

endmodule

// File: rtl/max_argmax_unit.sv
// Streamed max/argmax reduction: accepts len words, then holds {max, index} until consumed.
module max_argmax_unit
  import dnn_pkg::*;
#(
  parameter int unsigned DATA_W  = DNN_DATA_W,
  parameter int unsigned MAX_LEN = DNN_MAX_LEN,
  parameter int unsigned IDX_W   = $clog2(MAX_LEN)
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              start,
  input  logic [IDX_W:0]    len,
  input  logic              uMod,
  input  logic              in_valid,
  output logic              in_ready,
  input  logic [DATA_W-1:0] in_data,
  output logic              out_valid,
  input  logic              out_ready,
  output logic [DATA_W-1:0] out_max,
  output logic [IDX_W-1:0]  out_idx,
  output logic              busy,
  output logic              err
);

  localparam int unsigned LenW = IDX_W + 1;

  stateT             stateQ, stateD;
  logic [IDX_W-1:0]  cntQ, cntD;
  logic [IDX_W-1:0]  idxQ, idxD;
  logic [DATA_W-1:0] maxQ, maxD;
  logic [LenW-1:0]   lenQ, lenD;
  logic              uModQ, uModD;
  logic              errQ, errD;

  logic lenOk;
  logic lastElem;
  logic newMax;

  lt_cmp32 uLtCmp (
    .a    (maxQ),
    .b    (in_data),
    .uMod (uModQ),
    .lt   (newMax)
  );

  assign lenOk    = (len != '0) && (len <= LenW'(MAX_LEN));
  assign lastElem = ({1'b0, cntQ} == (lenQ - LenW'(1)));

  always_comb begin
    stateD = stateQ;
    cntD   = cntQ;
    idxD   = idxQ;
    maxD   = maxQ;
    lenD   = lenQ;
    uModD  = uModQ;
    errD   = 1'b0;
    unique case (stateQ)
      IDLE: begin
        if (start) begin
          if (lenOk) begin
            lenD   = len;
            uModD  = uMod;
            cntD   = '0;
            stateD = ACCUM;
          end else begin
            errD = 1'b1;
          end
        end
      end
      ACCUM: begin
        if (in_valid) begin
          // Strict less-than keeps the earliest index on ties.
          if ((cntQ == '0) || newMax) begin
            maxD = in_data;
            idxD = cntQ;
          end
          cntD = cntQ + IDX_W'(1);
          if (lastElem) stateD = DONE;
        end
      end
      DONE: begin
        if (out_ready) stateD = IDLE;
      end
      default: stateD = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      stateQ <= IDLE;
      cntQ   <= '0;
      idxQ   <= '0;
      maxQ   <= '0;
      lenQ   <= '0;
      uModQ  <= 1'b0;
      errQ   <= 1'b0;
    end else begin
      stateQ <= stateD;
      cntQ   <= cntD;
      idxQ   <= idxD;
      maxQ   <= maxD;
      lenQ   <= lenD;
      uModQ  <= uModD;
      errQ   <= errD;
    end
  end

  assign in_ready  = (stateQ == ACCUM);
  assign out_valid = (stateQ == DONE);
  assign busy      = (stateQ != IDLE);
  assign out_max   = maxQ;
  assign out_idx   = idxQ;
  assign err       = errQ;

endmodule

// File: tb/tb_max_argmax_unit.sv
// Directed bench for max_argmax_unit and its lt_cmp32 comparator.
module tb_max_argmax_unit;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        start;
  logic [4:0]  len;
  logic        uMod;
  logic        in_valid;
  logic        in_ready;
  logic [31:0] in_data;
  logic        out_valid;
  logic        out_ready;
  logic [31:0] out_max;
  logic [3:0]  out_idx;
  logic        busy;
  logic        err;

  logic [31:0] ca, cb;
  logic        cu, clt;

  int passCnt  = 0;
  int totalCnt = 0;

  logic [31:0] stream [16];

  typedef struct packed {
    logic        uMod;
    logic [4:0]  len;
    logic [31:0] w0;
    logic [31:0] w1;
    logic [31:0] w2;
    logic [31:0] w3;
    logic [31:0] expMax;
    logic [3:0]  expIdx;
  } vecT;

  vecT vecs [6];

  max_argmax_unit dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .start     (start),
    .len       (len),
    .uMod      (uMod),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .in_data   (in_data),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .out_max   (out_max),
    .out_idx   (out_idx),
    .busy      (busy),
    .err       (err)
  );

  lt_cmp32 uCmp (
    .a    (ca),
    .b    (cb),
    .uMod (cu),
    .lt   (clt)
  );

  always #5 clk = ~clk;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    totalCnt++;
    if (act === exp) passCnt++;
    else $display("FAIL %s: got %h, expected %h", name, act, exp);
  endtask

  // Runs one full operation over stream[0..l-1] with out_ready high once done.
  task automatic runOp(input string name, input logic u, input logic [4:0] l,
                       input logic [31:0] eMax, input logic [3:0] eIdx);
    @(negedge clk);
    start = 1'b1;
    len   = l;
    uMod  = u;
    @(negedge clk);
    start = 1'b0;
    check({name, " busy"}, busy, 1);
    check({name, " in_ready"}, in_ready, 1);
    for (int i = 0; i < int'(l); i++) begin
      check({name, " early out_valid"}, out_valid, 0);
      in_valid = 1'b1;
      in_data  = stream[i];
      @(negedge clk);
    end
    in_valid = 1'b0;
    check({name, " out_valid"}, out_valid, 1);
    check({name, " in_ready done"}, in_ready, 0);
    check({name, " out_max"}, out_max, eMax);
    check({name, " out_idx"}, out_idx, eIdx);
    out_ready = 1'b1;
    @(negedge clk);
    out_ready = 1'b0;
    check({name, " out_valid drop"}, out_valid, 0);
    check({name, " busy drop"}, busy, 0);
  endtask

  localparam logic [31:0] Corners [7] = '{32'h0, 32'h1, 32'h2, 32'h7FFF_FFFF,
                                          32'h8000_0000, 32'h8000_0001, 32'hFFFF_FFFF};

  initial begin
    rst_n     = 1'b1;
    start     = 1'b0;
    len       = '0;
    uMod      = 1'b0;
    in_valid  = 1'b0;
    in_data   = '0;
    out_ready = 1'b0;
    ca = '0;
    cb = '0;
    cu = 1'b0;

    // Comparator, exhaustive over corner values; expectation from native compares.
    for (int i = 0; i < 7; i++) begin
      for (int j = 0; j < 7; j++) begin
        for (int m = 0; m < 2; m++) begin
          ca = Corners[i];
          cb = Corners[j];
          cu = m[0];
          #1;
          if (m == 1) check("cmp unsigned", clt, (ca < cb) ? 1 : 0);
          else        check("cmp signed", clt, ($signed(ca) < $signed(cb)) ? 1 : 0);
        end
      end
    end

    #1 rst_n = 1'b0;
    #1;
    check("reset in_ready", in_ready, 0);
    check("reset out_valid", out_valid, 0);
    check("reset busy", busy, 0);
    check("reset err", err, 0);
    check("reset out_max", out_max, 0);
    check("reset out_idx", out_idx, 0);
    @(negedge clk);
    rst_n = 1'b1;

    vecs[0] = '{1'b1, 5'd4, 32'd5, 32'hFFFF_FFFF, 32'd7, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 4'd1};
    vecs[1] = '{1'b0, 5'd3, 32'hFFFF_FFFF, 32'h8000_0000, 32'd2, 32'd0, 32'd2, 4'd2};
    vecs[2] = '{1'b1, 5'd3, 32'hFFFF_FFFF, 32'h8000_0000, 32'd2, 32'd0, 32'hFFFF_FFFF, 4'd0};
    vecs[3] = '{1'b0, 5'd1, 32'h8000_0000, 32'd0, 32'd0, 32'd0, 32'h8000_0000, 4'd0};
    vecs[4] = '{1'b0, 5'd4, 32'h8000_0000, 32'h8000_0001, 32'h7FFF_FFFF, 32'd0,
                32'h7FFF_FFFF, 4'd2};
    vecs[5] = '{1'b1, 5'd4, 32'd3, 32'd3, 32'd3, 32'd3, 32'd3, 4'd0};

    for (int v = 0; v < 6; v++) begin
      stream[0] = vecs[v].w0;
      stream[1] = vecs[v].w1;
      stream[2] = vecs[v].w2;
      stream[3] = vecs[v].w3;
      runOp($sformatf("vec%0d", v), vecs[v].uMod, vecs[v].len, vecs[v].expMax, vecs[v].expIdx);
    end

    // Full-length vector -8..7: signed max is last, unsigned max is -1 at index 7.
    for (int i = 0; i < 16; i++) stream[i] = 32'(i) - 32'd8;
    runOp("len16 signed", 1'b0, 5'd16, 32'd7, 4'd15);
    runOp("len16 unsigned", 1'b1, 5'd16, 32'hFFFF_FFFF, 4'd7);

    // Input stalls and result backpressure.
    @(negedge clk);
    start = 1'b1; len = 5'd2; uMod = 1'b1;
    @(negedge clk);
    start = 1'b0;
    in_valid = 1'b1; in_data = 32'd10;
    @(negedge clk);
    in_valid = 1'b0; in_data = 32'hFFFF_FFFF;
    for (int i = 0; i < 2; i++) begin
      @(negedge clk);
      check("stall in_ready", in_ready, 1);
      check("stall out_valid", out_valid, 0);
    end
    in_valid = 1'b1; in_data = 32'd20;
    @(negedge clk);
    in_valid = 1'b0;
    for (int i = 0; i < 5; i++) begin
      check("bp out_valid", out_valid, 1);
      check("bp out_max", out_max, 32'd20);
      check("bp out_idx", out_idx, 1);
      @(negedge clk);
    end
    out_ready = 1'b1;
    @(negedge clk);
    out_ready = 1'b0;
    check("bp out_valid drop", out_valid, 0);
    check("bp busy drop", busy, 0);

    // Illegal lengths give a single err pulse and never leave IDLE.
    for (int k = 0; k < 3; k++) begin
      @(negedge clk);
      start = 1'b1;
      len   = (k == 0) ? 5'd0 : ((k == 1) ? 5'd17 : 5'd31);
      @(negedge clk);
      start = 1'b0;
      check("illegal err", err, 1);
      check("illegal busy", busy, 0);
      check("illegal in_ready", in_ready, 0);
      @(negedge clk);
      check("illegal err pulse", err, 0);
      check("illegal busy after", busy, 0);
    end

    // Asynchronous reset partway through an operation.
    @(negedge clk);
    start = 1'b1; len = 5'd8; uMod = 1'b1;
    @(negedge clk);
    start = 1'b0;
    for (int i = 0; i < 3; i++) begin
      in_valid = 1'b1;
      in_data  = 32'(100 * (i + 1));
      @(negedge clk);
    end
    in_valid = 1'b0;
    #2 rst_n = 1'b0;
    #1;
    check("midrst busy", busy, 0);
    check("midrst in_ready", in_ready, 0);
    check("midrst out_valid", out_valid, 0);
    check("midrst out_max", out_max, 0);
    check("midrst out_idx", out_idx, 0);
    check("midrst err", err, 0);
    #1 rst_n = 1'b1;
    begin
      int seen;
      seen = 0;
      for (int i = 0; i < 12; i++) begin
        @(negedge clk);
        if (out_valid || busy) seen++;
      end
      check("post-reset idle", seen, 0);
    end
    stream[0] = 32'h1234_5678;
    runOp("after reset", 1'b0, 5'd1, 32'h1234_5678, 4'd0);

    // start during ACCUM and DONE must not restart or flag.
    stream[0] = 32'hFFFF_FFFB;
    stream[1] = 32'd9;
    stream[2] = 32'd4;
    @(negedge clk);
    start = 1'b1; len = 5'd3; uMod = 1'b0;
    @(negedge clk);
    len = 5'd2; uMod = 1'b1;
    for (int i = 0; i < 3; i++) begin
      in_valid = 1'b1;
      in_data  = stream[i];
      @(negedge clk);
      check("ign err accum", err, 0);
      if (i == 1) check("ign no early done", out_valid, 0);
    end
    in_valid = 1'b0;
    for (int i = 0; i < 2; i++) begin
      @(negedge clk);
      check("ign done out_valid", out_valid, 1);
      check("ign done err", err, 0);
    end
    start = 1'b0;
    check("ign out_max", out_max, 32'd9);
    check("ign out_idx", out_idx, 1);
    out_ready = 1'b1;
    @(negedge clk);
    out_ready = 1'b0;
    check("ign out_valid drop", out_valid, 0);
    check("ign busy drop", busy, 0);
    @(negedge clk);
    check("ign stays idle", busy, 0);

    $display("%0d/%0d checks passed", passCnt, totalCnt);
    $finish;
  end

endmodule
